// File: rtl/cga_line_doubler.sv
// Scan doubler: captures each input scanline into one half of a ping-pong
// line RAM and replays the previous line twice at full clk rate.
module cga_line_doubler #(
    parameter int ADDR_WIDTH  = 10,
    parameter int HSYNC_WIDTH = 64
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       pix_ce,
    input  logic       line_reset,
    input  logic [3:0] video,
    output logic [3:0] dbl_video,
    output logic       dbl_hsync,
    output logic       dbl_second,
    output logic       overflow
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] FULL = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] ONE  = (ADDR_WIDTH + 1)'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PLAY1 = 2'd1,
        PLAY2 = 2'd2
    } state_t;

    logic [3:0] mem [0:2*DEPTH-1];

    state_t              state_q, state_d;
    logic                wr_bank_q, wr_bank_d;
    logic                rd_bank_q, rd_bank_d;
    logic [ADDR_WIDTH:0] wr_addr_q, wr_addr_d;
    logic [ADDR_WIDTH:0] rd_addr_q, rd_addr_d;
    logic [ADDR_WIDTH:0] rd_len_q, rd_len_d;
    logic                overflow_q, overflow_d;
    logic [3:0]          dbl_video_q, dbl_video_d;
    logic                dbl_hsync_q, dbl_hsync_d;
    logic                dbl_second_q, dbl_second_d;

    logic                mem_we;
    logic [ADDR_WIDTH:0] mem_waddr;
    logic                rd_last;
    logic                playing;

    // Write side: a line_reset starts the new bank, and a coincident pixel
    // lands at address 0 of that new bank.
    always_comb begin
        wr_bank_d  = wr_bank_q;
        wr_addr_d  = wr_addr_q;
        rd_bank_d  = rd_bank_q;
        rd_len_d   = rd_len_q;
        overflow_d = overflow_q;
        mem_we     = 1'b0;
        mem_waddr  = {wr_bank_q, wr_addr_q[ADDR_WIDTH-1:0]};
        if (line_reset) begin
            rd_len_d  = wr_addr_q;
            rd_bank_d = wr_bank_q;
            wr_bank_d = ~wr_bank_q;
            wr_addr_d = pix_ce ? ONE : '0;
            if (pix_ce) begin
                mem_we    = 1'b1;
                mem_waddr = {~wr_bank_q, {ADDR_WIDTH{1'b0}}};
            end
        end else if (pix_ce) begin
            if (wr_addr_q != FULL) begin
                mem_we    = 1'b1;
                wr_addr_d = wr_addr_q + ONE;
            end else begin
                overflow_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= video;
        end
    end

    assign rd_last = (rd_addr_q + ONE == rd_len_q);

    always_comb begin
        state_d   = state_q;
        rd_addr_d = rd_addr_q;
        unique case (state_q)
            IDLE: ;
            PLAY1: begin
                if (rd_last) begin
                    state_d   = PLAY2;
                    rd_addr_d = '0;
                end else begin
                    rd_addr_d = rd_addr_q + ONE;
                end
            end
            PLAY2: begin
                if (rd_last) begin
                    state_d   = IDLE;
                    rd_addr_d = '0;
                end else begin
                    rd_addr_d = rd_addr_q + ONE;
                end
            end
            default: begin
                state_d   = IDLE;
                rd_addr_d = '0;
            end
        endcase
        // A new line always wins, aborting whatever replay is in progress.
        if (line_reset) begin
            rd_addr_d = '0;
            state_d   = (wr_addr_q != '0) ? PLAY1 : IDLE;
        end
    end

    // The output flops double as the synchronous RAM read register.
    assign playing = (state_q != IDLE);

    always_comb begin
        dbl_video_d  = 4'h0;
        dbl_hsync_d  = 1'b0;
        dbl_second_d = 1'b0;
        if (playing) begin
            dbl_video_d  = mem[{rd_bank_q, rd_addr_q[ADDR_WIDTH-1:0]}];
            dbl_hsync_d  = (int'(rd_addr_q) < HSYNC_WIDTH);
            dbl_second_d = (state_q == PLAY2);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            wr_bank_q    <= 1'b0;
            rd_bank_q    <= 1'b1;
            wr_addr_q    <= '0;
            rd_addr_q    <= '0;
            rd_len_q     <= '0;
            overflow_q   <= 1'b0;
            dbl_video_q  <= 4'h0;
            dbl_hsync_q  <= 1'b0;
            dbl_second_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_bank_q    <= wr_bank_d;
            rd_bank_q    <= rd_bank_d;
            wr_addr_q    <= wr_addr_d;
            rd_addr_q    <= rd_addr_d;
            rd_len_q     <= rd_len_d;
            overflow_q   <= overflow_d;
            dbl_video_q  <= dbl_video_d;
            dbl_hsync_q  <= dbl_hsync_d;
            dbl_second_q <= dbl_second_d;
        end
    end

    assign dbl_video  = dbl_video_q;
    assign dbl_hsync  = dbl_hsync_q;
    assign dbl_second = dbl_second_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_cga_line_doubler.sv
// Directed bench for cga_line_doubler: per-cycle output log compared against
// hand-derived replay sequences.
module tb_cga_line_doubler;

    localparam int AW = 3;
    localparam int HW = 2;

    logic       clk = 1'b0;
    logic       reset;
    logic       pix_ce;
    logic       line_reset;
    logic [3:0] video;
    logic [3:0] dbl_video;
    logic       dbl_hsync;
    logic       dbl_second;
    logic       overflow;

    always #5 clk = ~clk;

    cga_line_doubler #(
        .ADDR_WIDTH (AW),
        .HSYNC_WIDTH(HW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .pix_ce    (pix_ce),
        .line_reset(line_reset),
        .video     (video),
        .dbl_video (dbl_video),
        .dbl_hsync (dbl_hsync),
        .dbl_second(dbl_second),
        .overflow  (overflow)
    );

    logic [3:0] lv[$];
    logic       lh[$];
    logic       ls[$];
    logic       lo[$];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clk cycle; log[i] holds the outputs just after the i-th edge.
    task automatic cyc(input logic r, input logic l, input logic c, input logic [3:0] v);
        reset      = r;
        line_reset = l;
        pix_ce     = c;
        video      = v;
        @(posedge clk);
        #1;
        lv.push_back(dbl_video);
        lh.push_back(dbl_hsync);
        ls.push_back(dbl_second);
        lo.push_back(overflow);
    endtask

    task automatic feed(input logic [3:0] v);
        cyc(1'b0, 1'b0, 1'b1, v);
        cyc(1'b0, 1'b0, 1'b0, 4'h0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 4'h0);
    endtask

    task automatic pulse(input logic c, input logic [3:0] v, output int k);
        cyc(1'b0, 1'b1, c, v);
        k = lv.size() - 1;
    endtask

    task automatic chk_replay(input string tag, input int k, input int len, input int ncyc,
                              input bit tail, input logic [3:0] px [8]);
        for (int j = 0; j < ncyc; j++) begin
            int p;
            p = j % len;
            chk($sformatf("%s_vid%0d", tag, j), lv[k+1+j], px[p]);
            chk($sformatf("%s_hs%0d", tag, j), lh[k+1+j], (p < HW));
            chk($sformatf("%s_sec%0d", tag, j), ls[k+1+j], (j >= len));
        end
        if (tail) begin
            chk({tag, "_tail_vid"}, lv[k+1+ncyc], 4'h0);
            chk({tag, "_tail_hs"}, lh[k+1+ncyc], 1'b0);
        end
    endtask

    initial begin
        int k0, ka, kb, kc, kd, ke, ko, kg, n;
        logic [3:0] pa [8];
        logic [3:0] pb [8];
        logic [3:0] pc [8];
        logic [3:0] pd [8];
        logic [3:0] pe [8];
        logic [3:0] po [8];
        logic [3:0] pg [8];
        pa = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8};
        pb = '{4'h9, 4'hA, 4'hB, 4'hC, 4'hD, 4'hE, 4'hF, 4'h3};
        pc = '{4'hF, 4'h1, 4'h2, 4'h3, 4'h0, 4'h0, 4'h0, 4'h0};
        pd = '{4'h8, 4'h7, 4'h6, 4'h5, 4'h4, 4'h3, 4'h2, 4'h1};
        pe = '{4'hC, 4'h5, 4'hA, 4'h6, 4'h0, 4'h0, 4'h0, 4'h0};
        po = pa;
        pg = '{4'h2, 4'h4, 4'h6, 4'h8, 4'hA, 4'hC, 4'hE, 4'h1};

        cyc(1'b1, 1'b0, 1'b0, 4'h0);
        cyc(1'b1, 1'b0, 1'b0, 4'h0);
        n = lv.size() - 1;
        chk("rst_vid", lv[n], 4'h0);
        chk("rst_hs", lh[n], 1'b0);
        chk("rst_sec", ls[n], 1'b0);
        chk("rst_ovf", lo[n], 1'b0);
        idle(2);

        // Empty lines: back-to-back line_reset with nothing captured.
        pulse(1'b0, 4'h0, k0);
        pulse(1'b0, 4'h0, n);
        idle(6);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("empty_vid%0d", i), lv[k0+i], 4'h0);
            chk($sformatf("empty_hs%0d", i), lh[k0+i], 1'b0);
        end

        for (int i = 0; i < 8; i++) feed(pa[i]);
        pulse(1'b0, 4'h0, ka);
        for (int i = 0; i < 8; i++) feed(pb[i]);
        pulse(1'b1, 4'hF, kb);              // coincident strobe: 0xF opens line C
        chk_replay("basic", ka, 8, 16, 1'b1, pa);

        cyc(1'b0, 1'b0, 1'b0, 4'h0);
        for (int i = 1; i < 4; i++) feed(pc[i]);
        idle(9);
        pulse(1'b0, 4'h0, kc);
        chk_replay("lineb", kb, 8, 16, 1'b1, pb);

        for (int i = 0; i < 8; i++) feed(pd[i]);
        pulse(1'b0, 4'h0, kd);
        chk_replay("coinc", kc, 4, 8, 1'b1, pc);

        // Abort: line_reset while PLAY2 of line D sits at address 3.
        for (int i = 0; i < 4; i++) feed(pe[i]);
        idle(3);
        pulse(1'b0, 4'h0, ke);
        idle(10);
        chk("abort_pos", ke - kd, 12);
        chk_replay("abortd", kd, 8, 12, 1'b0, pd);
        chk_replay("aborte", ke, 4, 8, 1'b1, pe);

        for (int i = 1; i <= 10; i++) begin
            feed(4'(i));
            n = lv.size() - 2;
            if (i == 8) chk("ovf_at8", lo[n], 1'b0);
            if (i == 9) chk("ovf_at9", lo[n], 1'b1);
        end
        pulse(1'b0, 4'h0, ko);
        for (int i = 0; i < 8; i++) feed(pg[i]);
        pulse(1'b0, 4'h0, kg);
        chk_replay("ovf", ko, 8, 16, 1'b1, po);
        chk("ovf_sticky", lo[ko+16], 1'b1);

        idle(3);
        chk("pre_rst_vid", lv[kg+1], pg[0]);
        chk("pre_rst_ovf", lo[kg+3], 1'b1);
        cyc(1'b1, 1'b0, 1'b0, 4'h0);
        cyc(1'b1, 1'b0, 1'b1, 4'h5);
        cyc(1'b1, 1'b0, 1'b0, 4'h0);
        idle(6);
        for (int i = kg + 4; i <= kg + 12; i++) begin
            chk($sformatf("midrst_vid%0d", i - kg), lv[i], 4'h0);
            chk($sformatf("midrst_hs%0d", i - kg), lh[i], 1'b0);
            chk($sformatf("midrst_sec%0d", i - kg), ls[i], 1'b0);
            chk($sformatf("midrst_ovf%0d", i - kg), lo[i], 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
